mem_access_unit: RTL and testbench

// - Load/store unit between the CPU's MEM pipeline stage and the 32-bit word RAM.
// - Translates byte/half/word loads and stores into aligned whole-word RAM accesses.
//   The RAM is little-endian: byte at addr+k sits in bits [8k+7:8k].
// - Sub-word stores use read-modify-write. Loads are sign- or zero-extended.
// - Flags misaligned, out-of-range and bad-size requests as errors and never touches the RAM for them.

---
 rtl/mem_access_unit_pkg.sv | 28 ++
 rtl/mem_access_unit_if.sv | 33 +++
 rtl/mem_access_unit_lane_fmt.sv | 48 ++++
 rtl/mem_access_unit.sv | 126 ++++++++++++
 tb/tb_mem_access_unit.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/mem_access_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_pkg
// Purpose  : Shared types and constants for the load/store unit.
// Revision : 1.0 - initial release
// ============================================================================
package mem_access_pkg;

    typedef enum logic [1:0] {
        SIZE_B   = 2'b00,
        SIZE_H   = 2'b01,
        SIZE_W   = 2'b10,
        SIZE_BAD = 2'b11
    } mem_size_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_RMW_RD = 3'd2,
        ST_WRITE  = 3'd3,
        ST_RESP   = 3'd4
    } mau_state_t;

    localparam int          BYTE_LANES      = 4;
    localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

endpackage
`default_nettype wire

// File: rtl/mem_access_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit_if
// Purpose  : Request/response and RAM-side signal bundle of the load/store unit.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_access_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_error;
    logic [31:0] resp_rdata;
    logic        ram_write_enable;
    logic [31:0] ram_address;
    logic [31:0] ram_in;
    logic [31:0] ram_out;

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, ram_out,
        output req_ready, resp_valid, resp_error, resp_rdata, ram_write_enable, ram_address, ram_in
    );

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, ram_out,
        input  req_ready, resp_valid, resp_error, resp_rdata, ram_write_enable, ram_address, ram_in
    );
endinterface
`default_nettype wire

// File: rtl/mem_access_unit_lane_fmt.sv
`default_nettype none
// ============================================================================
// Module   : mem_lane_fmt
// Purpose  : Combinational load lane extract/extend and store lane merge.
// Revision : 1.0 - initial release
// ============================================================================
module mem_lane_fmt
    import mem_access_pkg::*;
(
    input  wire logic [31:0] word_i,
    input  wire logic [31:0] old_word_i,
    input  wire logic [31:0] wdata_i,
    input  wire logic [1:0]  lane_i,
    input  mem_size_t        size_i,
    input  wire logic        unsigned_i,
    output logic      [31:0] rdata_o,
    output logic      [31:0] merged_o
);

    logic [7:0]  byte_w;
    logic [15:0] half_w;

    assign byte_w = word_i[{lane_i, 3'b000} +: 8];
    assign half_w = word_i[{lane_i[1], 4'b0000} +: 16];

    always_comb begin
        rdata_o = '0;
        case (size_i)
            SIZE_B:  rdata_o = {{24{byte_w[7] & ~unsigned_i}}, byte_w};
            SIZE_H:  rdata_o = {{16{half_w[15] & ~unsigned_i}}, half_w};
            SIZE_W:  rdata_o = word_i;
            default: rdata_o = '0;
        endcase
    end

    // Only the addressed lane(s) change; the rest of the old word passes through.
    always_comb begin
        merged_o = old_word_i;
        case (size_i)
            SIZE_B:  merged_o[{lane_i, 3'b000} +: 8]     = wdata_i[7:0];
            SIZE_H:  merged_o[{lane_i[1], 4'b0000} +: 16] = wdata_i[15:0];
            SIZE_W:  merged_o = wdata_i;
            default: merged_o = old_word_i;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Purpose  : Load/store unit turning byte/half/word requests into word RAM accesses.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int          MEM_BYTES = 32,
    parameter logic [31:0] ERR_RDATA = 32'hDEAD_BEEF
) (
    input  wire logic         clock,
    input  wire logic         reset_n,
    mem_access_unit_if.slave  bus
);

    mau_state_t  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    mem_size_t   size_q, size_d;
    logic        write_q, write_d;
    logic        unsigned_q, unsigned_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] base_q, base_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;

    mem_size_t   req_size_w;
    logic        req_err_w;
    logic [31:0] load_data_w;
    logic [31:0] merged_w;

    assign req_size_w = mem_size_t'(bus.req_size);

    // 33-bit compare keeps addresses near 2^32 from wrapping into range.
    assign req_err_w = (req_size_w == SIZE_BAD)
                    || ((req_size_w == SIZE_H) && bus.req_addr[0])
                    || ((req_size_w == SIZE_W) && (bus.req_addr[1:0] != 2'b00))
                    || (({1'b0, bus.req_addr & WORD_ALIGN_MASK} + 33'(BYTE_LANES - 1))
                        >= 33'(MEM_BYTES));

    mem_lane_fmt u_lane_fmt (
        .word_i     (bus.ram_out),
        .old_word_i (base_q),
        .wdata_i    (wdata_q),
        .lane_i     (addr_q[1:0]),
        .size_i     (size_q),
        .unsigned_i (unsigned_q),
        .rdata_o    (load_data_w),
        .merged_o   (merged_w)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            size_q     <= SIZE_B;
            write_q    <= 1'b0;
            unsigned_q <= 1'b0;
            wdata_q    <= '0;
            base_q     <= '0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            size_q     <= size_d;
            write_q    <= write_d;
            unsigned_q <= unsigned_d;
            wdata_q    <= wdata_d;
            base_q     <= base_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        size_d     = size_q;
        write_d    = write_q;
        unsigned_d = unsigned_q;
        wdata_d    = wdata_q;
        base_d     = base_q;
        err_d      = err_q;
        rdata_d    = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    addr_d     = bus.req_addr;
                    size_d     = req_size_w;
                    write_d    = bus.req_write;
                    unsigned_d = bus.req_unsigned;
                    wdata_d    = bus.req_wdata;
                    err_d      = req_err_w;
                    rdata_d    = req_err_w ? ERR_RDATA : '0;
                    if (req_err_w)                state_d = ST_RESP;
                    else if (!bus.req_write)      state_d = ST_LOAD;
                    else if (req_size_w == SIZE_W) state_d = ST_WRITE;
                    else                          state_d = ST_RMW_RD;
                end
            end
            ST_LOAD: begin
                rdata_d = load_data_w;
                state_d = ST_RESP;
            end
            ST_RMW_RD: begin
                base_d  = bus.ram_out;
                state_d = ST_WRITE;
            end
            ST_WRITE: state_d = ST_RESP;
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    assign bus.req_ready        = (state_q == ST_IDLE);
    assign bus.resp_valid       = (state_q == ST_RESP);
    assign bus.resp_error       = (state_q == ST_RESP) && err_q;
    assign bus.resp_rdata       = (state_q == ST_RESP) ? rdata_q : '0;
    assign bus.ram_write_enable = (state_q == ST_WRITE);
    assign bus.ram_address      = (state_q != ST_IDLE) ? (addr_q & WORD_ALIGN_MASK) : '0;
    assign bus.ram_in           = (state_q == ST_WRITE) ? merged_w : '0;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_unit
// Purpose  : Directed plus random bench for mem_access_unit against a byte-array model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    mem_access_unit_if bus();

    mem_access_unit #(
        .MEM_BYTES (28),
        .ERR_RDATA (32'hDEAD_BEEF)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    logic [31:0] ram [0:7] = '{default: 32'h0};
    assign bus.ram_out = ram[bus.ram_address[4:2]];
    always @(posedge clock) if (bus.ram_write_enable) ram[bus.ram_address[4:2]] <= bus.ram_in;

    byte unsigned ref_mem [0:31];
    int           n_checks = 0;
    int           n_err    = 0;
    logic [31:0]  last_rdata;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic run_req(input bit wr, input bit [1:0] sz, input bit uns,
                           input bit [31:0] addr, input bit [31:0] wd);
        bit          exp_err, seen;
        int          nb, exp_lat, writes, wcyc, cyc, idx;
        bit [31:0]   wa, exp_rd, exp_word, waddr, wdat;
        wa       = addr & 32'hFFFF_FFFC;
        exp_err  = (sz == 2'b11) || (sz == 2'b01 && addr[0]) ||
                   (sz == 2'b10 && addr[1:0] != 2'b00) || (longint'(wa) + 3 >= 28);
        nb       = 1 << sz;
        exp_rd   = '0;
        exp_word = '0;
        exp_lat  = 1;
        if (exp_err) begin
            exp_rd = 32'hDEAD_BEEF;
        end else if (!wr) begin
            for (int k = 0; k < nb; k++) begin
                idx    = int'(addr[4:0]) + k;
                exp_rd = exp_rd | (32'(ref_mem[idx]) << (8 * k));
            end
            if (!uns && exp_rd[8*nb-1])
                for (int k = nb; k < 4; k++) exp_rd = exp_rd | (32'hFF << (8 * k));
            exp_lat = 2;
        end else begin
            for (int k = 0; k < nb; k++) begin
                idx          = int'(addr[4:0]) + k;
                ref_mem[idx] = wd[8*k +: 8];
            end
            for (int k = 0; k < 4; k++) exp_word = exp_word | (32'(ref_mem[int'(wa[4:0]) + k]) << (8 * k));
            exp_lat = (nb == 4) ? 2 : 3;
        end

        @(negedge clock);
        chk("ready_idle", bus.req_ready, 1'b1);
        bus.req_valid    = 1'b1;
        bus.req_write    = wr;
        bus.req_size     = sz;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wd;
        @(posedge clock); #1;
        // Keep valid high with garbage fields while busy: must be ignored.
        bus.req_write    = 1'($urandom);
        bus.req_size     = 2'($urandom);
        bus.req_unsigned = 1'($urandom);
        bus.req_addr     = $urandom;
        bus.req_wdata    = $urandom;
        chk("ready_busy", bus.req_ready, 1'b0);
        writes = 0; wcyc = 0; waddr = '0; wdat = '0; seen = 1'b0; cyc = 1;
        while (!seen && cyc <= 8) begin
            if (bus.ram_write_enable) begin
                writes++; wcyc = cyc; waddr = bus.ram_address; wdat = bus.ram_in;
            end
            if (bus.resp_valid) begin
                seen = 1'b1;
                bus.req_valid = 1'b0;
            end else begin
                @(posedge clock); #1;
                cyc++;
            end
        end
        bus.req_valid = 1'b0;
        chk("resp_seen", seen, 1'b1);
        chk("latency", cyc, exp_lat);
        chk("resp_error", bus.resp_error, exp_err);
        chk("resp_rdata", bus.resp_rdata, exp_rd);
        last_rdata = bus.resp_rdata;
        chk("write_count", writes, (wr && !exp_err) ? 1 : 0);
        if (wr && !exp_err) begin
            chk("write_cycle", wcyc, exp_lat - 1);
            chk("write_addr", waddr, wa);
            chk("write_data", wdat, exp_word);
        end
        @(posedge clock); #1;
        chk("resp_one_cycle", bus.resp_valid, 1'b0);
    endtask

    initial begin
        int r;
        bit [1:0] sz;
        for (int i = 0; i < 32; i++) ref_mem[i] = 8'h00;
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'b00;
        bus.req_unsigned = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;

        #2;
        chk("rst_ready", bus.req_ready, 1'b1);
        chk("rst_resp_valid", bus.resp_valid, 1'b0);
        chk("rst_resp_error", bus.resp_error, 1'b0);
        chk("rst_resp_rdata", bus.resp_rdata, 32'h0);
        chk("rst_we", bus.ram_write_enable, 1'b0);
        chk("rst_ram_addr", bus.ram_address, 32'h0);
        chk("rst_ram_in", bus.ram_in, 32'h0);
        @(negedge clock);
        reset_n = 1'b1;

        run_req(1, 2'b10, 0, 32'h04, 32'h8899_AABB);
        run_req(1, 2'b10, 0, 32'h08, 32'h1122_3344);
        run_req(0, 2'b01, 0, 32'h06, 32'h0);
        chk("ld_half_s_06", last_rdata, 32'hFFFF_8899);
        run_req(0, 2'b00, 1, 32'h05, 32'h0);
        chk("ld_byte_u_05", last_rdata, 32'h0000_00AA);
        run_req(0, 2'b00, 0, 32'h04, 32'h0);
        chk("ld_byte_s_04", last_rdata, 32'hFFFF_FFBB);
        run_req(1, 2'b00, 0, 32'h09, 32'h0000_00EE);
        run_req(0, 2'b10, 0, 32'h08, 32'h0);
        chk("ld_word_08", last_rdata, 32'h1122_EE44);
        run_req(1, 2'b10, 0, 32'h0C, 32'hCAFE_F00D);
        run_req(1, 2'b01, 0, 32'h0E, 32'h0000_BEEF);
        run_req(0, 2'b10, 1, 32'h0C, 32'h0);
        chk("ld_word_0c", last_rdata, 32'hBEEF_F00D);

        run_req(0, 2'b10, 0, 32'h02, 32'h0);
        run_req(1, 2'b01, 0, 32'h03, 32'h1234);
        run_req(0, 2'b11, 0, 32'h00, 32'h0);
        run_req(0, 2'b10, 0, 32'h1C, 32'h0);
        run_req(0, 2'b10, 0, 32'h18, 32'h0);

        // Reset in the middle of a byte store's write cycle.
        @(negedge clock);
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = 2'b00;
        bus.req_unsigned = 1'b0; bus.req_addr = 32'h10; bus.req_wdata = 32'h77;
        @(posedge clock); #1;
        bus.req_valid = 1'b0;
        @(posedge clock); #1;
        chk("mid_we_high", bus.ram_write_enable, 1'b1);
        #1 reset_n = 1'b0;
        #1;
        chk("mid_we_drop", bus.ram_write_enable, 1'b0);
        chk("mid_resp_valid", bus.resp_valid, 1'b0);
        chk("mid_ready", bus.req_ready, 1'b1);
        chk("mid_ram_addr", bus.ram_address, 32'h0);
        chk("mid_ram_in", bus.ram_in, 32'h0);
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clock); #1;
            chk("post_rst_no_resp", bus.resp_valid, 1'b0);
        end
        run_req(0, 2'b10, 0, 32'h0C, 32'h0);
        chk("post_rst_load", last_rdata, 32'hBEEF_F00D);

        for (int i = 0; i < 40; i++) begin
            r  = $urandom_range(0, 9);
            sz = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
            run_req(1'($urandom), sz, 1'($urandom), 32'($urandom_range(0, 31)), $urandom);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
